// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI retire packer.
//   rvfi_rec_t   - one channel's RVFI fields, excluding valid and order
//   rvfi_state_e - packer run state (RUN / DRAIN / HALTED)
//   ORDER_W      - width of the per-channel order stamp
// XLEN / ILEN come from RISCV_FORMAL_XLEN / RISCV_FORMAL_ILEN (default 32).
// NRET defaults to RISCV_FORMAL_NRET (default 1).
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_ILEN
`define RISCV_FORMAL_ILEN 32
`endif

package rvfi_pkg;
  localparam int XLEN    = `RISCV_FORMAL_XLEN;
  localparam int ILEN    = `RISCV_FORMAL_ILEN;
  localparam int MASK_W  = XLEN / 8;
  localparam int ORDER_W = 64;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rvfi_state_e;

  typedef struct packed {
    logic [ILEN-1:0]   insn;
    logic              trap;
    logic              halt;
    logic              intr;
    logic [1:0]        mode;
    logic [1:0]        ixl;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_rec_t;
endpackage

// File: rtl/rvfi_rec_fifo.sv
// Record FIFO for the RVFI retire packer: one push per cycle, pop of
// 0..NRET entries per cycle, NRET head entries exposed combinationally.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (clears pointers/count)
//   push_i          write push_rec_i at the tail (caller guarantees space)
//   pop_n_i         number of head entries to drop this cycle (<= count_o)
//   count_o         registered occupancy
//   head_o[i]       entry i positions from the head (valid for i < count_o)
module rvfi_rec_fifo
  import rvfi_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int NRET  = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(NRET + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  rvfi_rec_t            push_rec_i,
  input  logic [PW-1:0]        pop_n_i,
  output logic [CW-1:0]        count_o,
  output rvfi_rec_t [NRET-1:0] head_o
);
  // DEPTH is a power of two, so masking the pointer sum gives the wrap.
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  rvfi_rec_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q + AW'(1)) & PTR_MASK;
      rd_ptr_q <= (rd_ptr_q + AW'(pop_n_i)) & PTR_MASK;
      count_q  <= count_q + CW'(push_i) - CW'(pop_n_i);
    end
  end

  // Storage is not reset: occupancy is what defines valid contents.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_rec_i;
  end

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      head_o[i] = mem_q[(rd_ptr_q + AW'(i)) & PTR_MASK];
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/rvfi_retire_packer.sv
// RVFI retire packer: accepts one retired-instruction record per cycle
// (valid/ready), queues it, stamps a monotonic 64-bit order at emission and
// drives up to NRET records per cycle onto channel-packed rvfi_* outputs
// (channel c at [c*W +: W]). Valid channels are always 0..k-1; idle
// channels read all-zero.
// Ports:
//   clock, reset_n         clock, async active-low reset
//   in_valid / in_ready    record handshake; in_ready also needs reset_n high
//   in_*                   record fields
//   rvfi_*                 registered, NRET-channel RVFI output set
//   halted                 halt record emitted and queue empty
// Build option: RVFI_PACKER_X0_MASK_EN forces rvfi_rd_wdata to 0 for
// records with rd_addr == 0; otherwise rd_wdata passes through.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
module rvfi_retire_packer
  import rvfi_pkg::*;
#(
  parameter int NRET  = `RISCV_FORMAL_NRET,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_trap,
  input  logic                      in_halt,
  input  logic                      in_intr,
  input  logic [1:0]                in_mode,
  input  logic [1:0]                in_ixl,
  input  logic [ILEN-1:0]           in_instruction,
  input  logic [4:0]                in_rs1_addr,
  input  logic [4:0]                in_rs2_addr,
  input  logic [4:0]                in_rd_addr,
  input  logic [XLEN-1:0]           in_rs1_rdata,
  input  logic [XLEN-1:0]           in_rs2_rdata,
  input  logic [XLEN-1:0]           in_rd_wdata,
  input  logic [XLEN-1:0]           in_pc_rdata,
  input  logic [XLEN-1:0]           in_pc_wdata,
  input  logic [XLEN-1:0]           in_mem_addr,
  input  logic [MASK_W-1:0]         in_mem_rmask,
  input  logic [MASK_W-1:0]         in_mem_wmask,
  input  logic [XLEN-1:0]           in_mem_rdata,
  input  logic [XLEN-1:0]           in_mem_wdata,
  output logic [NRET-1:0]           rvfi_valid,
  output logic [NRET*ORDER_W-1:0]   rvfi_order,
  output logic [NRET*ILEN-1:0]      rvfi_insn,
  output logic [NRET-1:0]           rvfi_trap,
  output logic [NRET-1:0]           rvfi_halt,
  output logic [NRET-1:0]           rvfi_intr,
  output logic [NRET*2-1:0]         rvfi_mode,
  output logic [NRET*2-1:0]         rvfi_ixl,
  output logic [NRET*5-1:0]         rvfi_rs1_addr,
  output logic [NRET*5-1:0]         rvfi_rs2_addr,
  output logic [NRET*XLEN-1:0]      rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]      rvfi_rs2_rdata,
  output logic [NRET*5-1:0]         rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]      rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]      rvfi_mem_addr,
  output logic [NRET*MASK_W-1:0]    rvfi_mem_rmask,
  output logic [NRET*MASK_W-1:0]    rvfi_mem_wmask,
  output logic [NRET*XLEN-1:0]      rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]      rvfi_mem_wdata,
  output logic                      halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NRET + 1);

  rvfi_rec_t                       in_rec;
  logic                            push;
  logic [CW-1:0]                   count;
  logic [PW-1:0]                   pop_n;
  rvfi_rec_t [NRET-1:0]            head;

  rvfi_state_e                     state_q, state_d;
  logic [ORDER_W-1:0]              order_cnt_q, order_cnt_d;
  logic [NRET-1:0]                 valid_q, valid_d;
  logic [NRET-1:0][ORDER_W-1:0]    order_q, order_d;
  rvfi_rec_t [NRET-1:0]            rec_q, rec_d;

  always_comb begin
    in_rec           = '0;
    in_rec.insn      = in_instruction;
    in_rec.trap      = in_trap;
    in_rec.halt      = in_halt;
    in_rec.intr      = in_intr;
    in_rec.mode      = in_mode;
    in_rec.ixl       = in_ixl;
    in_rec.rs1_addr  = in_rs1_addr;
    in_rec.rs2_addr  = in_rs2_addr;
    in_rec.rd_addr   = in_rd_addr;
    in_rec.rs1_rdata = in_rs1_rdata;
    in_rec.rs2_rdata = in_rs2_rdata;
    in_rec.rd_wdata  = in_rd_wdata;
    in_rec.pc_rdata  = in_pc_rdata;
    in_rec.pc_wdata  = in_pc_wdata;
    in_rec.mem_addr  = in_mem_addr;
    in_rec.mem_rmask = in_mem_rmask;
    in_rec.mem_wmask = in_mem_wmask;
    in_rec.mem_rdata = in_mem_rdata;
    in_rec.mem_wdata = in_mem_wdata;
  end

  // Credit comes only from the registered count: a pop in the same cycle
  // does not free a slot, so a full queue stalls one cycle while draining.
  assign in_ready = reset_n && (state_q == RUN) && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // k = min(count, NRET)
  assign pop_n = (count > CW'(NRET)) ? PW'(NRET) : PW'(count);

  rvfi_rec_fifo #(.DEPTH(DEPTH), .NRET(NRET)) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .push_i     (push),
    .push_rec_i (in_rec),
    .pop_n_i    (pop_n),
    .count_o    (count),
    .head_o     (head)
  );

  // Halt record is always the last one queued (in_ready drops on accept),
  // so an empty queue in DRAIN means it has already been emitted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push && in_rec.halt) state_d = DRAIN;
      DRAIN:   if (count == '0) state_d = HALTED;
      default: ;
    endcase
  end

  always_comb begin
    valid_d     = '0;
    order_d     = '0;
    rec_d       = '0;
    order_cnt_d = order_cnt_q + ORDER_W'(pop_n);
    for (int c = 0; c < NRET; c++) begin
      if (c < int'(pop_n)) begin
        valid_d[c] = 1'b1;
        order_d[c] = order_cnt_q + ORDER_W'(c);
        rec_d[c]   = head[c];
`ifdef RVFI_PACKER_X0_MASK_EN
        if (head[c].rd_addr == 5'd0) rec_d[c].rd_wdata = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      order_cnt_q <= '0;
      valid_q     <= '0;
      order_q     <= '0;
      rec_q       <= '0;
    end else begin
      state_q     <= state_d;
      order_cnt_q <= order_cnt_d;
      valid_q     <= valid_d;
      order_q     <= order_d;
      rec_q       <= rec_d;
    end
  end

  for (genvar c = 0; c < NRET; c++) begin : g_ch
    assign rvfi_valid[c]                        = valid_q[c];
    assign rvfi_order[c*ORDER_W +: ORDER_W]     = order_q[c];
    assign rvfi_insn[c*ILEN +: ILEN]            = rec_q[c].insn;
    assign rvfi_trap[c]                         = rec_q[c].trap;
    assign rvfi_halt[c]                         = rec_q[c].halt;
    assign rvfi_intr[c]                         = rec_q[c].intr;
    assign rvfi_mode[c*2 +: 2]                  = rec_q[c].mode;
    assign rvfi_ixl[c*2 +: 2]                   = rec_q[c].ixl;
    assign rvfi_rs1_addr[c*5 +: 5]              = rec_q[c].rs1_addr;
    assign rvfi_rs2_addr[c*5 +: 5]              = rec_q[c].rs2_addr;
    assign rvfi_rd_addr[c*5 +: 5]               = rec_q[c].rd_addr;
    assign rvfi_rs1_rdata[c*XLEN +: XLEN]       = rec_q[c].rs1_rdata;
    assign rvfi_rs2_rdata[c*XLEN +: XLEN]       = rec_q[c].rs2_rdata;
    assign rvfi_rd_wdata[c*XLEN +: XLEN]        = rec_q[c].rd_wdata;
    assign rvfi_pc_rdata[c*XLEN +: XLEN]        = rec_q[c].pc_rdata;
    assign rvfi_pc_wdata[c*XLEN +: XLEN]        = rec_q[c].pc_wdata;
    assign rvfi_mem_addr[c*XLEN +: XLEN]        = rec_q[c].mem_addr;
    assign rvfi_mem_rmask[c*MASK_W +: MASK_W]   = rec_q[c].mem_rmask;
    assign rvfi_mem_wmask[c*MASK_W +: MASK_W]   = rec_q[c].mem_wmask;
    assign rvfi_mem_rdata[c*XLEN +: XLEN]       = rec_q[c].mem_rdata;
    assign rvfi_mem_wdata[c*XLEN +: XLEN]       = rec_q[c].mem_wdata;
  end

  assign halted = (state_q == HALTED);
endmodule

// File: doc/rvfi_retire_packer.md
# rvfi_retire_packer

Producer side of the packed RVFI bus. The core hands it one retired-instruction record per cycle over a valid/ready handshake. The block buffers records in a small FIFO, stamps each one with a monotonic 64-bit `order`, and drives up to NRET records per cycle onto the channel-packed `rvfi_*` outputs. Those outputs are the ones every per-channel checker slices by channel index. The block sits between the core's retirement stage and the formal wrapper's `RVFI_OUTPUTS`.

## Interface
Parameters:
- `NRET`, default `` `RISCV_FORMAL_NRET `` (1): number of output channels.
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥ NRET.
- `XLEN` / `ILEN`: taken from `` `RISCV_FORMAL_XLEN `` / `` `RISCV_FORMAL_ILEN ``; not overridable.

Ports:
- `clock`  in  1: sole clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: record offered.
- `in_ready`  out  1: record accepted on the edge when `in_valid && in_ready`.
- `in_trap`, `in_halt`, `in_intr`  in  1 each: record flags.
- `in_mode`, `in_ixl`  in  2 each: record privilege mode and ixl.
- `in_instruction`  in  ILEN: retired instruction word.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each: register addresses.
- `in_rs1_rdata`, `in_rs2_rdata`, `in_rd_wdata`, `in_pc_rdata`, `in_pc_wdata`, `in_mem_addr`, `in_mem_rdata`, `in_mem_wdata`  in  XLEN each: record data.
- `in_mem_rmask`, `in_mem_wmask`  in  XLEN/8 each: memory byte masks.
- `rvfi_*`  out  NRET × field width, channel c at `[c*W +: W]`: the full RVFI output set, including `rvfi_valid` and `rvfi_order` (64 bits per channel).
- `halted`  out  1: a halt record has been emitted and the FIFO is empty.

## Operation
- FIFO entry: all `in_*` fields. Order is not stored; it is assigned at emission.
- Each cycle, k = min(count, NRET) head entries pop into the output registers.
  - Entry i of the k goes to channel i, so valid channels are always 0..k−1 contiguous.
  - Channels k..NRET−1 have valid = 0 and all fields = 0.
- Order stamping:
  - Channel i gets `order_cnt + i`.
  - `order_cnt` then advances by k, modulo 2^64. Wrap from 2^64−1 to 0 is legal and silent.
- `in_ready = (state == RUN) && (count < DEPTH)`.
  - `count` is the registered value.
  - A same-cycle pop gives no credit, so a full FIFO stalls for one cycle even while draining.
- State machine:
  - RUN: normal operation. Accepting a record with `in_halt = 1` moves to DRAIN.
  - DRAIN: `in_ready = 0`. Remaining entries keep emitting. When `count` reaches 0 after the halt record has been emitted, move to HALTED.
  - HALTED: `in_ready = 0`, `rvfi_valid = 0`, `halted = 1`. Stays until reset.
- Records accepted in the same cycle the halt record pops are impossible, because `in_ready` is already 0.
- Reset, asserted at any time including mid-DRAIN:
  - FIFO is discarded; `count`, `order_cnt` and pointers go to 0; state goes to RUN.
  - All outputs go to 0, except `in_ready`, which reads 1 once `reset_n` is high.

## Timing
- The RVFI outputs are registered and have no backpressure. Each valid beat lasts exactly one cycle.
- Latency:
  - Record accepted at edge E0 is written to the FIFO.
  - It pops at E1 and is visible on `rvfi_*` during the cycle after E1. Minimum latency is 2 edges.
- Sustained rate:
  - One record per cycle at full throughput when NRET = 1.
  - With NRET > 1, bursts that accumulated during a stall drain at up to NRET per cycle.
- Reset values: every output 0, `in_ready` 0 while `reset_n` is low. `reset_n` deassertion is synchronized to `clock` externally.

## Configuration
- `RVFI_PACKER_X0_MASK_EN`
  - Defined: when `rd_addr == 0`, `rvfi_rd_wdata` is forced to 0 at emission, as RVFI requires. This holds even if the core drives garbage.
  - Undefined: `rd_wdata` passes through unmodified. The core is then responsible, and the `reg`/`causal` checks catch violations.

## Structure
- Shared package `rvfi_pkg`:
  - typedef `rvfi_rec_t`, a packed struct of one channel's fields excluding valid and order;
  - typedef `rvfi_state_e`, with values RUN, DRAIN, HALTED;
  - localparam `ORDER_W = 64`.
- One sub-module, `rvfi_rec_fifo`:
  - parameterized on DEPTH and NRET;
  - one push per cycle; pop of 0..NRET entries per cycle;
  - exposes `count` and NRET head entries.
- The top level holds the state machine, order counter, output registers and the X0 mask.

## Test plan
- Single record, NRET = 1. Push pc_rdata = 0x100, rd_addr = 5 → `rvfi_valid` = 1 for one cycle, 2 edges after acceptance, with order = 0, pc_rdata = 0x100.
- Backpressure, NRET = 1, DEPTH = 4, `in_valid` held high for 10 cycles.
  - `in_ready` never drops, since steady state is count ≤ 1.
  - Orders 0..9 appear back to back.
- Burst drain, NRET = 2, DEPTH = 4. Fill the FIFO with 3 records before the first pop → beats are {ch0: order 0, ch1: order 1}, then {ch0: order 2, ch1 invalid and all-zero}.
- Halt. Push records A, B(halt = 1), C.
  - C is never accepted.
  - A and B emit; `halted` rises the cycle after B's beat.
  - `rvfi_valid` stays 0 for 20 further cycles.
- Order wrap. Preload `order_cnt` = 2^64−1 by force, then push 2 records → orders 0xFFFF_FFFF_FFFF_FFFF, then 0.
- Reset mid-DRAIN, and the mask. Assert `reset_n` low with 2 entries queued.
  - Outputs go to 0 immediately; after release, the next record has order = 0.
  - With `RVFI_PACKER_X0_MASK_EN` defined, a record with rd_addr = 0, rd_wdata = 0xDEAD emits rd_wdata = 0.
